// File: rtl/grant_xfer_ctrl.sv
// Serializes the payload of the one-hot granted requester as BEATS beats on a
// valid/ready bus, then acknowledges the arbiter and the served requester.
module grant_xfer_ctrl #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   grant,
    input  logic [4*DATA_W*BEATS-1:0]    req_data,
    input  logic                         bus_ready,
    output logic                         bus_valid,
    output logic [DATA_W-1:0]            bus_data,
    output logic                         bus_last,
    output logic [1:0]                   bus_ch,
    output logic                         ack,
    output logic [3:0]                   done,
    output logic                         busy,
    output logic                         err
);

    localparam int P     = DATA_W * BEATS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             state_r;
    logic [P-1:0]       shift_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               onehot_s;
    logic               multi_s;
    logic [1:0]         idx_s;
    logic [P-1:0]       payload_s;

    // The current beat is always the low slice of the payload shift register.
    assign bus_data = shift_r[DATA_W-1:0];

    // Classify the grant and select the matching channel payload.
    always_comb begin
        onehot_s = 1'b0;
        multi_s  = 1'b0;
        idx_s    = 2'd0;
        case (grant)
            4'b0000: begin
                onehot_s = 1'b0;
            end
            4'b0001: begin
                onehot_s = 1'b1;
                idx_s    = 2'd0;
            end
            4'b0010: begin
                onehot_s = 1'b1;
                idx_s    = 2'd1;
            end
            4'b0100: begin
                onehot_s = 1'b1;
                idx_s    = 2'd2;
            end
            4'b1000: begin
                onehot_s = 1'b1;
                idx_s    = 2'd3;
            end
            default: begin
                multi_s = 1'b1;
            end
        endcase
        payload_s = req_data[idx_s*P +: P];
    end

    // Transfer FSM with all handshake and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            cnt_r     <= '0;
            bus_valid <= 1'b0;
            bus_last  <= 1'b0;
            bus_ch    <= 2'd0;
            ack       <= 1'b0;
            done      <= 4'b0000;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ack  <= 1'b0;
            done <= 4'b0000;
            err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (onehot_s) begin
                        shift_r   <= payload_s;
                        bus_ch    <= idx_s;
                        cnt_r     <= '0;
                        bus_valid <= 1'b1;
                        bus_last  <= (BEATS == 1);
                        busy      <= 1'b1;
                        state_r   <= XFER;
                    end else if (multi_s) begin
                        err <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                XFER: begin
                    if (bus_ready) begin
                        shift_r <= shift_r >> DATA_W;
                        cnt_r   <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_CNT) begin
                            bus_valid <= 1'b0;
                            bus_last  <= 1'b0;
                            ack       <= 1'b1;
                            done      <= 4'b0001 << bus_ch;
                            state_r   <= ACK;
                        end else begin
                            // Look one beat ahead so bus_last stays a plain flop.
                            bus_last <= ((cnt_r + CNT_W'(1)) == LAST_CNT);
                        end
                    end else begin
                        state_r <= XFER;
                    end
                end
                ACK: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    bus_valid <= 1'b0;
                    bus_last  <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_xfer_ctrl.sv
// Bench for grant_xfer_ctrl: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_grant_xfer_ctrl;

    localparam int DW = 8;
    localparam int NB = 4;
    localparam int P  = DW * NB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0]     grant     = 4'b0000;
    logic [4*P-1:0] req_data  = '0;
    logic           bus_ready = 1'b0;
    logic           bus_valid;
    logic [DW-1:0]  bus_data;
    logic           bus_last;
    logic [1:0]     bus_ch;
    logic           ack;
    logic [3:0]     done;
    logic           busy;
    logic           err;

    logic [3:0]     g1 = 4'b0000;
    logic [31:0]    d1 = '0;
    logic           r1 = 1'b1;
    logic           v1;
    logic [7:0]     dd1;
    logic           l1;
    logic [1:0]     c1;
    logic           a1;
    logic [3:0]     dn1;
    logic           b1;
    logic           e1;

    int checks = 0;
    int errors = 0;

    grant_xfer_ctrl #(.DATA_W(DW), .BEATS(NB)) dut (
        .clk(clk), .rst(rst), .grant(grant), .req_data(req_data),
        .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
        .bus_last(bus_last), .bus_ch(bus_ch), .ack(ack), .done(done),
        .busy(busy), .err(err)
    );

    grant_xfer_ctrl #(.DATA_W(8), .BEATS(1)) dut1 (
        .clk(clk), .rst(rst), .grant(g1), .req_data(d1),
        .bus_ready(r1), .bus_valid(v1), .bus_data(dd1),
        .bus_last(l1), .bus_ch(c1), .ack(a1), .done(dn1),
        .busy(b1), .err(e1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue of beats still owed on the bus, plus pending ack/err.
    logic [7:0] mq[$];
    int         m_ch  = 0;
    bit         m_ack = 1'b0;
    bit         m_err = 1'b0;
    bit         m_rst = 1'b1;

    always @(negedge clk) begin
        chk("bus_valid", bus_valid, mq.size() > 0);
        chk("bus_last", bus_last, mq.size() == 1);
        chk("bus_ch", bus_ch, m_ch);
        chk("ack", ack, m_ack);
        chk("done", done, m_ack ? (4'b0001 << m_ch) : 4'b0000);
        chk("busy", busy, (mq.size() > 0) || m_ack);
        chk("err", err, m_err);
        if (mq.size() > 0)
            chk("bus_data", bus_data, mq[0]);
        else if (m_rst)
            chk("bus_data_rst", bus_data, 8'h00);

        if (rst) begin
            mq.delete();
            m_ch  = 0;
            m_ack = 1'b0;
            m_err = 1'b0;
            m_rst = 1'b1;
        end else begin
            m_err = 1'b0;
            if (m_ack) begin
                m_ack = 1'b0;
            end else if (mq.size() > 0) begin
                if (bus_ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_ack = 1'b1;
                end
            end else if ($countones(grant) == 1) begin
                for (int k = 0; k < 4; k++)
                    if (grant[k]) m_ch = k;
                for (int b = 0; b < NB; b++)
                    mq.push_back(req_data[m_ch*P + b*DW +: DW]);
                m_rst = 1'b0;
            end else if (grant != 4'b0000) begin
                m_err = 1'b1;
            end
        end
    end

    logic [3:0] walk [3];
    int         starts [3];
    int         chs [3];
    int         nk;
    int         wi;
    logic       pv;
    int         sel;

    initial begin
        walk = '{4'b0001, 4'b0010, 4'b1000};
        starts = '{0, 0, 0};
        chs = '{0, 0, 0};
        repeat (2) tick();
        chk("rst_valid", bus_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", bus_data, 8'h00);
        rst = 1'b0;
        bus_ready = 1'b1;

        // Single transfer from channel 2.
        req_data = {$urandom, $urandom, $urandom, $urandom};
        req_data[2*P +: P] = 32'hDDCCBBAA;
        grant = 4'b0100;
        tick();
        grant = 4'b0000;
        chk("single_b0", bus_data, 8'hAA);
        chk("single_ch", bus_ch, 2'd2);
        tick(); chk("single_b1", bus_data, 8'hBB);
        tick(); chk("single_b2", bus_data, 8'hCC);
        tick(); chk("single_b3", bus_data, 8'hDD);
        chk("single_last", bus_last, 1'b1);
        tick(); chk("single_ack", ack, 1'b1);
        chk("single_done", done, 4'b0100);
        tick(); chk("single_busy", busy, 1'b0);

        // Backpressure on beat BB for three cycles.
        grant = 4'b0100;
        tick();
        grant = 4'b0000;
        chk("bp_b0", bus_data, 8'hAA);
        tick();
        bus_ready = 1'b0;
        repeat (3) begin
            chk("bp_hold", bus_data, 8'hBB);
            chk("bp_hold_valid", bus_valid, 1'b1);
            tick();
        end
        bus_ready = 1'b1;
        chk("bp_hold", bus_data, 8'hBB);
        tick(); chk("bp_b2", bus_data, 8'hCC);
        tick(); chk("bp_b3", bus_data, 8'hDD);
        tick(); chk("bp_ack", ack, 1'b1);
        tick();

        // Back-to-back grants with mid-transfer disturbance of grant/req_data.
        nk = 0;
        wi = 0;
        pv = bus_valid;
        grant = walk[0];
        for (int c = 0; c < 60 && nk < 3; c++) begin
            tick();
            if (bus_valid && !pv) begin
                starts[nk] = c;
                chs[nk] = bus_ch;
                nk++;
            end
            pv = bus_valid;
            if (bus_valid && nk > 0 && c == starts[nk-1] + 1) begin
                grant = 4'($urandom);
                req_data = {$urandom, $urandom, $urandom, $urandom};
            end
            if (ack) begin
                wi++;
                grant = (wi < 3) ? walk[wi] : 4'b0000;
            end
        end
        chk("b2b_count", nk, 3);
        chk("b2b_ch0", chs[0], 0);
        chk("b2b_ch1", chs[1], 1);
        chk("b2b_ch2", chs[2], 3);
        chk("b2b_period01", starts[1] - starts[0], 6);
        chk("b2b_period12", starts[2] - starts[1], 6);
        grant = 4'b0000;
        repeat (8) tick();

        // Illegal grant for two cycles, then a legal one.
        grant = 4'b0110;
        tick();
        chk("illegal_err1", err, 1'b1);
        chk("illegal_valid1", bus_valid, 1'b0);
        tick();
        chk("illegal_err2", err, 1'b1);
        chk("illegal_valid2", bus_valid, 1'b0);
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        chk("illegal_recover", bus_valid, 1'b1);
        chk("illegal_err_clr", err, 1'b0);
        repeat (6) tick();

        // Reset after the second beat has been accepted.
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", bus_valid, 1'b0);
        chk("midrst_data", bus_data, 8'h00);
        chk("midrst_last", bus_last, 1'b0);
        chk("midrst_ch", bus_ch, 2'd0);
        chk("midrst_busy", busy, 1'b0);
        repeat (6) begin
            chk("midrst_noack", {ack, done}, 5'b0);
            tick();
        end

        // Single-beat build: period of three cycles with the grant held.
        d1 = $urandom;
        d1[8 +: 8] = 8'h5A;
        g1 = 4'b0010;
        tick();
        chk("b1_valid", v1, 1'b1);
        chk("b1_last", l1, 1'b1);
        chk("b1_data", dd1, 8'h5A);
        chk("b1_ch", c1, 2'd1);
        tick();
        chk("b1_ack", a1, 1'b1);
        chk("b1_done", dn1, 4'b0010);
        chk("b1_valid_off", v1, 1'b0);
        tick();
        chk("b1_idle", b1, 1'b0);
        tick();
        chk("b1_period", v1, 1'b1);
        g1 = 4'b0000;
        repeat (3) tick();

        // Randomized traffic, including occasional resets and illegal grants.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)
                grant = 4'b0001 << $urandom_range(0, 3);
            else if (sel < 8)
                grant = 4'b0000;
            else
                grant = 4'($urandom);
            bus_ready = ($urandom_range(0, 9) < 7);
            req_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        rst = 1'b0;
        grant = 4'b0000;
        bus_ready = 1'b1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grant_xfer_ctrl.md
# grant_xfer_ctrl

Downstream consumer of the 4-requester arbiter's one-hot `grant`. It latches the granted requester's payload and serializes it as `BEATS` beats onto a shared valid/ready bus. When the last beat is accepted it pulses `ack` back to the arbiter so the arbiter can advance to the next grant. It also gives the winning requester a per-channel `done` pulse.

## Interface
- `DATA_W`, default 8: bus beat width in bits.
- `BEATS`, default 4: beats per transaction, ≥1. Payload width is P = DATA_W*BEATS.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `grant`  in  4  one-hot grant from the arbiter; bit k selects requester k.
- `req_data`  in  4*P  requester payloads; channel k is `req_data[k*P +: P]`.
- `bus_ready`  in  1  sink accepts the current beat.
- `bus_valid`  out  1  beat on `bus_data` is valid.
- `bus_data`  out  DATA_W  current beat. Beat 0 is payload bits [DATA_W-1:0].
- `bus_last`  out  1  marks the final beat of a transaction.
- `bus_ch`  out  2  binary index of the channel being transferred.
- `ack`  out  1  one-cycle pulse: transaction complete, arbiter may advance.
- `done`  out  4  one-hot pulse to the served requester, coincident with `ack`.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse: illegal grant sampled in IDLE.

## Operation
- FSM states: IDLE, XFER, ACK.
- **IDLE**
  - If `grant` is exactly one-hot: capture that channel's payload into a P-bit shift register, capture the channel index into `bus_ch`, clear the beat counter, go to XFER.
  - If `grant` has 2 or more bits set: pulse `err` next cycle, stay in IDLE, capture nothing.
  - If `grant` is 0: stay in IDLE.
- **XFER**
  - `bus_valid`=1 and `bus_data` = low DATA_W bits of the shift register.
  - On `bus_valid && bus_ready`: shift right by DATA_W and increment the beat counter.
  - `bus_last`=1 when the counter equals BEATS-1.
  - When the last beat is accepted, go to ACK.
- **ACK**
  - `ack`=1 and `done`=decoded `bus_ch`, for one cycle; `bus_valid`=0. Then go to IDLE.
- Beat counter width is $clog2(BEATS), minimum 1 bit. With BEATS=1, `bus_last`=1 on the only beat.
- `grant` and `req_data` are ignored outside IDLE. Changes to them mid-transfer must not alter `bus_data` or `bus_ch`.
- While `bus_valid && !bus_ready`, `bus_data`, `bus_last` and `bus_ch` hold stable.
- `rst` takes priority over everything, including mid-XFER. The FSM returns to IDLE, the in-flight transaction is dropped, and no `ack` or `done` is issued for it.

## Timing
- Reset values: `bus_valid`=0, `bus_data`=0, `bus_last`=0, `bus_ch`=0, `ack`=0, `done`=4'b0000, `busy`=0, `err`=0, state=IDLE, counter=0.
- All outputs are registered or decoded from registered state only. No combinational path from `grant`/`bus_ready` to outputs, except that `bus_data` may update from the shift register the cycle after acceptance.
- Latency:
  - Grant one-hot in cycle t → `bus_valid`=1 in cycle t+1.
  - Last beat accepted in cycle u → `ack`=1 in cycle u+1 → IDLE in u+2, where `grant` is sampled again.
- Minimum transaction period with `bus_ready` held high: BEATS+2 cycles.
- Arbiter contract: `grant` must reflect the next arbitration result by the cycle after `ack`. A stale grant in that cycle is served again.
- `err` asserts in cycle t+1 for an illegal grant in cycle t. It repeats each cycle while the illegal grant persists in IDLE.

## Test plan
- **Single transfer:** reset 2 cycles; DATA_W=8, BEATS=4, `req_data` ch2 = 32'hDDCCBBAA, `grant`=4'b0100, `bus_ready`=1.
  - Required: beats AA, BB, CC, DD on cycles 1–4 with `bus_ch`=2 and `bus_last` on DD.
  - Required: `ack`=1 and `done`=4'b0100 on cycle 5; `busy` low on cycle 6.
- **Backpressure:** as above, with `bus_ready` low for 3 cycles during beat BB.
  - Required: BB held stable with `bus_valid`=1; no beat skipped or duplicated; `ack` 3 cycles later than in the single-transfer case.
- **Back-to-back:** `grant` walks 0001→0010→1000, changing on each `ack`.
  - Required: three transactions with `bus_ch` 0, 1, 3, each 6 cycles apart.
  - Required: a `grant` change during XFER does not affect the active transfer.
- **Illegal grant:** `grant`=4'b0110 for 2 cycles in IDLE.
  - Required: `err` pulses on 2 cycles, `bus_valid` stays 0, then `grant`=4'b0001 starts a normal transfer.
- **Reset mid-operation:** `rst`=1 for 1 cycle after beat 2 is accepted.
  - Required: next cycle all outputs at reset values; no `ack` or `done` for the dropped transaction.
- **BEATS=1 build:** one transfer.
  - Required: a single beat with `bus_last`=1, `ack` on the next cycle, period 3 cycles.
